// File: rtl/seg7_bcd_scan_counter.sv
// seg7_bcd_scan_counter
// Multi-digit BCD up/down counter with a time-multiplexed 7-segment driver.
// A free-running prescaler produces a one-cycle tick every TICK_DIV clocks.
// The counter steps on tick && en, with carry/borrow rippling across digits.
// A scan counter rotates the active digit every SCAN_DIV clocks.
// The wrap output pulses for one cycle whenever the full range rolls over.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN. When it is defined,
// leading zero digits above digit 0 are shown as a blank pattern.
module seg7_bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int SCAN_DIV   = 25000
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  output logic [7:0]            seg_dat,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic                  wrap
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0]     SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_RESET  = ~NUM_DIGITS'(1);

  // Segment pattern a..g,dp (bit7..bit0). Non-BCD codes show nothing.
  function automatic logic [7:0] decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hFC;
      4'd1:    s = 8'h60;
      4'd2:    s = 8'hDA;
      4'd3:    s = 8'hF2;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'hB6;
      4'd6:    s = 8'hBE;
      4'd7:    s = 8'hE0;
      4'd8:    s = 8'hFE;
      4'd9:    s = 8'hF6;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  logic [PRESC_W-1:0]             r_presc;
  logic [SCAN_W-1:0]              r_scan_cnt;
  logic [IDX_W-1:0]               r_idx;
  logic [NUM_DIGITS-1:0][3:0]     r_digit;
  logic                           r_wrap;
  logic [7:0]                     r_seg_dat;
  logic [NUM_DIGITS-1:0]          r_seg_sel;

  logic                           w_tick;
  logic                           w_step;
  logic                           w_full_wrap;
  logic [NUM_DIGITS-1:0][3:0]     w_digit_next;
  logic                           w_scan_last;
  logic [3:0]                     w_sel_digit;
  logic                           w_sel_blank;
  logic [NUM_DIGITS-1:0]          w_blank;
  logic [NUM_DIGITS-1:0]          w_sel_next;

  assign w_tick      = (r_presc == PRESC_LAST);
  // clr has priority, so a clear coinciding with a tick neither steps nor wraps.
  assign w_step      = w_tick & en & ~clr;
  assign w_scan_last = (r_scan_cnt == SCAN_LAST);

  // Prescaler free-runs 0..TICK_DIV-1, independent of en and clr.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Ripple the +1/-1 step through the digits; leftover carry means full wrap.
  always_comb begin
    logic v_carry;
    v_carry      = 1'b1;
    w_digit_next = r_digit;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v_carry) begin
        if (up_dn) begin
          if (r_digit[i] == 4'd9) begin
            w_digit_next[i] = 4'd0;
          end else begin
            w_digit_next[i] = r_digit[i] + 4'd1;
            v_carry         = 1'b0;
          end
        end else begin
          if (r_digit[i] == 4'd0) begin
            w_digit_next[i] = 4'd9;
          end else begin
            w_digit_next[i] = r_digit[i] - 4'd1;
            v_carry         = 1'b0;
          end
        end
      end
    end
    w_full_wrap = v_carry;
  end

  // Count value: clear wins, otherwise take the rippled value on a step.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (w_step) begin
      r_digit <= w_digit_next;
    end
  end

  // Wrap pulse is high the cycle after the rolling-over step.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step & w_full_wrap;
    end
  end

  // Scan timer and digit index; with one digit the index stays at 0.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (w_scan_last) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
    end
  end

  // Leading-zero detection: digit i blanks when it and every higher digit is 0.
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] w_digit_zero;
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
    assign w_digit_zero[gi] = (r_digit[gi] == 4'd0);
    if (gi == 0) begin : g_lsd
      assign w_blank[gi] = 1'b0;
    end else begin : g_upper
      assign w_blank[gi] = &w_digit_zero[NUM_DIGITS-1:gi];
    end
  end
`else
  assign w_blank = '0;
`endif

  // Active-low select pattern for the current index.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
    assign w_sel_next[gi] = ~(r_idx == IDX_W'(gi));
  end

  // Pick the digit value and blank flag addressed by the scan index.
  always_comb begin
    w_sel_digit = 4'd0;
    w_sel_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_digit = r_digit[i];
        w_sel_blank = w_blank[i];
      end
    end
  end

  // Select and segment data are registered together so they always match.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_seg_sel <= SEL_RESET;
      r_seg_dat <= 8'hFC;
    end else begin
      r_seg_sel <= w_sel_next;
      r_seg_dat <= w_sel_blank ? 8'h00 : decode(w_sel_digit);
    end
  end

  assign seg_sel = r_seg_sel;
  assign seg_dat = r_seg_dat;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_seg7_bcd_scan_counter.sv
// Directed testbench for seg7_bcd_scan_counter (NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2).
// Build with +define+SEG7_LEADING_ZERO_BLANK_EN to exercise leading-zero blanking.
module tb_seg7_bcd_scan_counter;

  logic       clk   = 1'b0;
  logic       nRst  = 1'b1;
  logic       en    = 1'b0;
  logic       up_dn = 1'b1;
  logic       clr   = 1'b0;
  logic [7:0] seg_dat;
  logic [1:0] seg_sel;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  int presc_m;
  int wrap_hi  = 0;
  int base;

  seg7_bcd_scan_counter #(
    .NUM_DIGITS(2),
    .TICK_DIV  (4),
    .SCAN_DIV  (2)
  ) dut (
    .clk    (clk),
    .nRst   (nRst),
    .en     (en),
    .up_dn  (up_dn),
    .clr    (clr),
    .seg_dat(seg_dat),
    .seg_sel(seg_sel),
    .wrap   (wrap)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: a tick cycle is one where presc_m == 3.
  always @(posedge clk or negedge nRst) begin
    if (!nRst) presc_m <= 0;
    else       presc_m <= (presc_m == 3) ? 0 : presc_m + 1;
  end

  // Count cycles in which wrap is high, sampled mid-cycle.
  always @(negedge clk) begin
    if (wrap === 1'b1) wrap_hi <= wrap_hi + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  // Apply en=1 for exactly n tick cycles, one step each.
  task automatic run_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      do @(negedge clk); while (presc_m != 3);
      en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  // Same as one tick but with clr raised in the tick cycle.
  task automatic clr_on_tick();
    do @(negedge clk); while (presc_m != 3);
    en  = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Wait (bounded) until the given slot is selected, then compare its pattern.
  task automatic check_slot(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      @(negedge clk);
      if (seg_sel === sel) found = 1'b1;
    end
    check({tag, "_sel"}, 32'(found), 32'd1);
    if (found) check({tag, "_dat"}, 32'(seg_dat), 32'(exp));
  endtask

  task automatic check_val(input string tag, input logic [7:0] d1, input logic [7:0] d0);
    check_slot({tag, "_d0"}, 2'b10, d0);
    check_slot({tag, "_d1"}, 2'b01, d1);
  endtask

  initial begin
    // Power-on reset, checked before any clock edge.
    #1 nRst = 1'b0;
    #2;
    check("rst0_sel",  32'(seg_sel), 32'h2);
    check("rst0_dat",  32'(seg_dat), 32'hFC);
    check("rst0_wrap", 32'(wrap),    32'h0);
    @(negedge clk);
    nRst = 1'b1;

    // Up count 00 -> 10, then on to 37.
    run_ticks(10);
    check_val("up10", 8'h60, 8'hFC);
    run_ticks(27);
    check_val("v37", 8'hF2, 8'hE0);

    // Asynchronous reset mid-count, observed without an edge.
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    check("rst37_sel",  32'(seg_sel), 32'h2);
    check("rst37_dat",  32'(seg_dat), 32'hFC);
    check("rst37_wrap", 32'(wrap),    32'h0);
    @(negedge clk);
    nRst = 1'b1;
    check_val("post_rst", 8'hFC, 8'hFC);

    // 100 up ticks from 00: exactly one wrap, at 99 -> 00.
    base = wrap_hi;
    run_ticks(99);
    check_val("v99", 8'hF6, 8'hF6);
    check("no_wrap_to_99", 32'(wrap_hi - base), 32'd0);
    run_ticks(1);
    check_val("wrap_up", 8'hFC, 8'hFC);
    check("wrap_up_cycles", 32'(wrap_hi - base), 32'd1);

    // Down from 00 wraps to 99, then 98 without another pulse.
    up_dn = 1'b0;
    run_ticks(1);
    check_val("wrap_dn", 8'hF6, 8'hF6);
    check("wrap_dn_cycles", 32'(wrap_hi - base), 32'd2);
    run_ticks(1);
    check_val("v98", 8'hF6, 8'hFE);
    check("v98_no_wrap", 32'(wrap_hi - base), 32'd2);

    // Clear, count to 42, then hold with en=0 across 3 ticks.
    up_dn = 1'b1;
    do_clr();
    check_val("clr00", 8'hFC, 8'hFC);
    run_ticks(42);
    check_val("v42", 8'h66, 8'hDA);
    repeat (12) @(negedge clk);
    check_val("hold42", 8'h66, 8'hDA);

    // clr coincident with a tick and en=1 overrides the step.
    clr_on_tick();
    check_val("clr_tick", 8'hFC, 8'hFC);
    up_dn = 1'b0;
    clr_on_tick();
    check_val("clr_tick_dn", 8'hFC, 8'hFC);
    check("clr_no_wrap", 32'(wrap_hi - base), 32'd2);

    // Leading digit display for value 05.
    up_dn = 1'b1;
    run_ticks(5);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    check_val("v05", 8'h00, 8'hB6);
`else
    check_val("v05", 8'hFC, 8'hB6);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
